even_parity_checker: RTL and testbench
======================================

Name: even_parity_checker

Overview:
- Even-parity checker for one data word plus its received parity bit.
- The error output asserts when the total number of 1s across data_in and parity_in is odd.
- Provides a combinational error flag, a one-cycle registered result with valid, a sticky error flag, and saturating beat and error counters.
- Sits at the receive side of a byte link, after the deserializer and before the consumer or status registers.

Parameters:
- DATA_WIDTH, default 8: width of data_in in bits; legal range 1 or more.
- CNT_WIDTH, default 16: width of the beat and error counters; legal range 1 or more.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  received data word.
- parity_in  input  1  received even-parity bit for data_in.
- valid_in  input  1  qualifies data_in/parity_in for the registered path and counters.
- clear  input  1  synchronous clear of err_sticky, err_count and chk_count.
- error  output  1  combinational parity error.
- error_q  output  1  registered parity error for the last valid beat.
- valid_out  output  1  registered copy of valid_in; marks error_q as fresh.
- err_sticky  output  1  set by any valid errored beat; held until clear or rst.
- err_count  output  CNT_WIDTH  number of valid beats with error, saturating.
- chk_count  output  CNT_WIDTH  number of valid beats checked, saturating.

Behaviour:
- error = XOR-reduction of {data_in, parity_in}.
  - Purely combinational, zero latency, independent of valid_in, clk and rst.
  - error = 0 when the 1s count over data_in plus parity_in is even; error = 1 when it is odd.
- Reset: while rst = 1, asynchronously:
  - error_q = 0, valid_out = 0, err_sticky = 0, err_count = 0, chk_count = 0.
  - rst dominates clear and valid_in.
  - If rst is asserted mid-stream, the in-flight result is discarded.
- Each rising clk edge with rst = 0:
  - valid_out <= valid_in.
  - If valid_in = 1: error_q <= error. If valid_in = 0: error_q holds its value.
  - Latency is 1 cycle from a valid input beat to valid_out/error_q.
- Counters and sticky flag, on each rising edge with rst = 0:
  - If clear = 1: err_sticky <= 0, err_count <= 0, chk_count <= 0. The beat in the same cycle is not counted. error_q and valid_out still update normally.
  - Else if valid_in = 1:
    - chk_count increments by 1 and saturates at all-ones.
    - If error = 1: err_count increments by 1 and saturates at all-ones; err_sticky <= 1.
  - Saturated counters stay at all-ones; they never wrap.
- No handshake back-pressure: every valid_in beat is accepted.
- Unknown (X) inputs are not specially handled.

Test Plan:
- Combinational check, no clock required:
  - data_in = 8'b00000000, parity_in = 1 -> error = 1.
  - data_in = 8'b01010101, parity_in = 1 -> error = 1.
  - data_in = 8'b01110010, parity_in = 1 -> error = 1.
  - data_in = 8'b00001111, parity_in = 0 -> error = 0.
  - data_in = 8'b00000001, parity_in = 1 -> error = 0.
- Registered path:
  - Drive valid_in = 1 with 8'b01010101 / parity_in = 0, then 8'b01010101 / parity_in = 1 on consecutive cycles.
  - Required: valid_out = 1 with error_q = 0, then error_q = 1, each one cycle after its beat.
  - Drop valid_in -> valid_out = 0 and error_q holds 1.
- Counters: 5 valid beats, 2 of them errored -> chk_count = 5, err_count = 2, err_sticky = 1. Then pulse clear -> all three read 0 the next cycle.
- Clear collision: clear = 1 and valid_in = 1 with an errored beat in the same cycle -> counters = 0, err_sticky = 0, error_q = 1, valid_out = 1.
- Saturation: with CNT_WIDTH = 2, apply 6 errored valid beats -> err_count = 3 and chk_count = 3, both holding with no wrap.
- Async reset: assert rst between clock edges while the counters are nonzero -> all registered outputs go to 0 immediately, without waiting for a clock edge. error still follows the inputs.

Source files
------------

// File: rtl/even_parity_checker.sv
// Even-parity checker: combinational error flag, one-cycle registered result,
// sticky error flag and saturating beat/error counters.
module even_parity_checker #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    input  logic                  valid_in,
    input  logic                  clear,
    output logic                  error,
    output logic                  error_q,
    output logic                  valid_out,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  chk_count
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic                 error_d;
    logic                 err_sticky_d;
    logic [CNT_WIDTH-1:0] err_count_d;
    logic [CNT_WIDTH-1:0] chk_count_d;

    // Odd number of ones across the word plus its parity bit is an error.
    assign error = ^{data_in, parity_in};

    always_comb begin
        error_d      = error_q;
        err_sticky_d = err_sticky;
        err_count_d  = err_count;
        chk_count_d  = chk_count;

        if (valid_in) begin
            error_d = error;
        end

        // Clear wins over the beat arriving in the same cycle.
        if (clear) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
            chk_count_d  = '0;
        end else if (valid_in) begin
            if (chk_count != CntMax) begin
                chk_count_d = chk_count + CntOne;
            end
            if (error) begin
                err_sticky_d = 1'b1;
                if (err_count != CntMax) begin
                    err_count_d = err_count + CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q    <= 1'b0;
            valid_out  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
        end else begin
            error_q    <= error_d;
            valid_out  <= valid_in;
            err_sticky <= err_sticky_d;
            err_count  <= err_count_d;
            chk_count  <= chk_count_d;
        end
    end

endmodule

// File: tb/tb_even_parity_checker.sv
// Directed, table-driven bench for even_parity_checker; a second instance with
// 2-bit counters covers saturation.
module tb_even_parity_checker;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        parity_in;
    logic        valid_in;
    logic        clear;

    logic        error, error_q, valid_out, err_sticky;
    logic [15:0] err_count, chk_count;

    logic        s_error, s_error_q, s_valid_out, s_err_sticky;
    logic [1:0]  s_err_count, s_chk_count;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       err;
    } vec_t;

    vec_t comb_vecs[7];
    vec_t beat_vecs[5];

    even_parity_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .valid_in   (valid_in),
        .clear      (clear),
        .error      (error),
        .error_q    (error_q),
        .valid_out  (valid_out),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .chk_count  (chk_count)
    );

    even_parity_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .valid_in   (valid_in),
        .clear      (clear),
        .error      (s_error),
        .error_q    (s_error_q),
        .valid_out  (s_valid_out),
        .err_sticky (s_err_sticky),
        .err_count  (s_err_count),
        .chk_count  (s_chk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag, input logic [15:0] chk, input logic [15:0] err,
                                  input logic sticky);
        check({tag, " chk_count"}, {16'b0, chk_count}, {16'b0, chk});
        check({tag, " err_count"}, {16'b0, err_count}, {16'b0, err});
        check({tag, " err_sticky"}, {31'b0, err_sticky}, {31'b0, sticky});
    endtask

    initial begin
        int exp_chk;
        int exp_err;

        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        data_in   = 8'h00;
        parity_in = 1'b0;
        valid_in  = 1'b0;
        clear     = 1'b0;

        comb_vecs[0] = '{data: 8'b00000000, par: 1'b1, err: 1'b1};
        comb_vecs[1] = '{data: 8'b01010101, par: 1'b1, err: 1'b1};
        comb_vecs[2] = '{data: 8'b01110010, par: 1'b1, err: 1'b1};
        comb_vecs[3] = '{data: 8'b00001111, par: 1'b0, err: 1'b0};
        comb_vecs[4] = '{data: 8'b00000001, par: 1'b1, err: 1'b0};
        comb_vecs[5] = '{data: 8'b11111111, par: 1'b0, err: 1'b0};
        comb_vecs[6] = '{data: 8'b10000000, par: 1'b0, err: 1'b1};

        // Five beats, two errored, last one clean so error_q ends at 0.
        beat_vecs[0] = '{data: 8'b00000011, par: 1'b0, err: 1'b0};
        beat_vecs[1] = '{data: 8'b00000111, par: 1'b0, err: 1'b1};
        beat_vecs[2] = '{data: 8'b11000000, par: 1'b1, err: 1'b1};
        beat_vecs[3] = '{data: 8'b10101010, par: 1'b0, err: 1'b0};
        beat_vecs[4] = '{data: 8'b00010000, par: 1'b1, err: 1'b0};

        #2 rst = 1'b1;
        #2;
        check("reset error_q", {31'b0, error_q}, 32'd0);
        check("reset valid_out", {31'b0, valid_out}, 32'd0);
        check_counters("reset", 16'd0, 16'd0, 1'b0);

        // Combinational path works with rst held and no clock dependency.
        for (int i = 0; i < 7; i++) begin
            data_in   = comb_vecs[i].data;
            parity_in = comb_vecs[i].par;
            #1;
            check($sformatf("comb error vec%0d", i), {31'b0, error}, {31'b0, comb_vecs[i].err});
        end

        @(negedge clk);
        rst = 1'b0;

        // Registered path.
        tick();
        valid_in  = 1'b1;
        data_in   = 8'b01010101;
        parity_in = 1'b0;
        tick();
        check("reg beat0 valid_out", {31'b0, valid_out}, 32'd1);
        check("reg beat0 error_q", {31'b0, error_q}, 32'd0);
        parity_in = 1'b1;
        tick();
        check("reg beat1 valid_out", {31'b0, valid_out}, 32'd1);
        check("reg beat1 error_q", {31'b0, error_q}, 32'd1);
        valid_in  = 1'b0;
        parity_in = 1'b0;
        tick();
        check("reg idle valid_out", {31'b0, valid_out}, 32'd0);
        check("reg idle error_q holds", {31'b0, error_q}, 32'd1);
        check_counters("reg path", 16'd2, 16'd1, 1'b1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_counters("clear1", 16'd0, 16'd0, 1'b0);

        // Counter table.
        exp_chk = 0;
        exp_err = 0;
        for (int i = 0; i < 5; i++) begin
            valid_in  = 1'b1;
            data_in   = beat_vecs[i].data;
            parity_in = beat_vecs[i].par;
            tick();
            exp_chk++;
            if (beat_vecs[i].err) exp_err++;
            check($sformatf("beat%0d error_q", i), {31'b0, error_q}, {31'b0, beat_vecs[i].err});
        end
        valid_in = 1'b0;
        tick();
        check_counters("five beats", 16'(exp_chk), 16'(exp_err), 1'b1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_counters("clear2", 16'd0, 16'd0, 1'b0);
        check("clear2 error_q holds", {31'b0, error_q}, 32'd0);

        // Clear collides with an errored valid beat.
        clear     = 1'b1;
        valid_in  = 1'b1;
        data_in   = 8'b00000001;
        parity_in = 1'b0;
        tick();
        clear    = 1'b0;
        valid_in = 1'b0;
        check_counters("collision", 16'd0, 16'd0, 1'b0);
        check("collision error_q", {31'b0, error_q}, 32'd1);
        check("collision valid_out", {31'b0, valid_out}, 32'd1);

        // Saturation on the 2-bit instance; wide instance keeps counting.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_in  = 1'b1;
            data_in   = 8'b00000000;
            parity_in = 1'b1;
            tick();
            check($sformatf("sat err_count beat%0d", i), {30'b0, s_err_count},
                  (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("sat chk_count beat%0d", i), {30'b0, s_chk_count},
                  (i < 3) ? 32'(i + 1) : 32'd3);
        end
        valid_in = 1'b0;
        tick();
        check("sat err_count hold", {30'b0, s_err_count}, 32'd3);
        check("sat chk_count hold", {30'b0, s_chk_count}, 32'd3);
        check("sat err_sticky", {31'b0, s_err_sticky}, 32'd1);
        check_counters("wide after six", 16'd6, 16'd6, 1'b1);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("async error_q", {31'b0, error_q}, 32'd0);
        check("async valid_out", {31'b0, valid_out}, 32'd0);
        check_counters("async", 16'd0, 16'd0, 1'b0);
        check("async sat err_count", {30'b0, s_err_count}, 32'd0);
        data_in   = 8'b00100000;
        parity_in = 1'b0;
        #1;
        check("async comb error", {31'b0, error}, 32'd1);
        parity_in = 1'b1;
        #1;
        check("async comb error clean", {31'b0, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
